// File: rtl/dffram_pkg.sv
// Shared definitions for the banked DFFRAM controller.
//   state_e : controller FSM states (CLEAR = post-reset zero fill, RUN = normal)
//   ctrl_t  : the FSM state register together with the READY flag it drives.
//             Keeping both in one struct lets a checker bind to a single signal.
//   BYTE_W  : width of one byte lane
//   clog2   : constant-friendly ceiling log2 used for address widths
package dffram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    state_e state;
    logic   ready;
  } ctrl_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dffram_bank.sv
// One BANK_W-wide, WORDS-deep RAM bank with byte write enables.
//   CLK, RSTn : clock, asynchronous active-low reset (read register only)
//   i_en      : access enable; no memory activity when low
//   i_we      : byte write enables; all-zero with i_en high is a read
//   i_addr    : word address
//   i_di      : write data
//   o_do      : registered read data, updated only by reads, 1-cycle latency
module dffram_bank
  import dffram_pkg::*;
#(
  parameter int  WORDS  = 256,
  parameter int  BANK_W = 32,
  localparam int AW     = clog2(WORDS),
  localparam int NBB    = BANK_W / BYTE_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              i_en,
  input  logic [NBB-1:0]    i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [BANK_W-1:0] i_di,
  output logic [BANK_W-1:0] o_do
);

  logic [BANK_W-1:0] r_mem [WORDS];
  logic [BANK_W-1:0] r_do;

  // Storage is deliberately not reset; the controller zero-fills it instead.
  always_ff @(posedge CLK) begin
    if (i_en) begin
      for (int k = 0; k < NBB; k++) begin
        if (i_we[k]) r_mem[i_addr][k*BYTE_W +: BYTE_W] <= i_di[k*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register holds its value across writes and idle cycles.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_do <= '0;
    end else if (i_en && (i_we == '0)) begin
      r_do <= r_mem[i_addr];
    end
  end

  assign o_do = r_do;

endmodule

// File: rtl/dffram_banked_ctrl.sv
// Wide byte-writable RAM built from DATA_W/BANK_W identical banks, with an
// optional post-reset zero fill, optional output register and read strobe.
//   CLK, RSTn : clock, asynchronous active-low reset
//   EN        : access request, accepted when READY=1 at a rising edge
//   WE        : byte write enables (DATA_W/8); all-zero = read
//   A         : word address, common to all banks
//   Di        : write data
//   Do        : read data, held until the next read result
//   VALID     : one-cycle strobe marking a fresh read result on Do
//   READY     : high once the block accepts accesses
// Handshake: an access is taken on every rising edge where EN=1 and READY=1;
// there is no back-pressure. Reads return in issue order, one per cycle,
// flagged by VALID exactly 1 (OUT_REG=0) or 2 (OUT_REG=1) edges after the
// accepting edge.
module dffram_banked_ctrl
  import dffram_pkg::*;
#(
  parameter int  WORDS          = 256,
  parameter int  DATA_W         = 64,
  parameter int  BANK_W         = 32,
  parameter int  OUT_REG        = 1,
  parameter int  CLEAR_ON_RESET = 1,
  localparam int AW             = clog2(WORDS),
  localparam int NBYTES         = DATA_W / BYTE_W
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              EN,
  input  logic [NBYTES-1:0] WE,
  input  logic [AW-1:0]     A,
  input  logic [DATA_W-1:0] Di,
  output logic [DATA_W-1:0] Do,
  output logic              VALID,
  output logic              READY
);

  localparam int     NB          = DATA_W / BANK_W;
  localparam int     BANK_BYTES  = BANK_W / BYTE_W;
  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  if (DATA_W % BANK_W != 0) begin : g_err_data_w
    $error("DATA_W must be a multiple of BANK_W");
  end
  if (BANK_W % BYTE_W != 0) begin : g_err_bank_w
    $error("BANK_W must be a multiple of 8");
  end
  if ((WORDS & (WORDS - 1)) != 0) begin : g_err_words
    $error("WORDS must be a power of two");
  end

  ctrl_t             r_ctrl;
  state_e            w_state_next;
  logic [AW-1:0]     r_clr_cnt;

  logic              w_accept;
  logic              r_req_en;
  logic [NBYTES-1:0] r_req_we;
  logic [AW-1:0]     r_req_addr;
  logic [DATA_W-1:0] r_req_di;
  logic              r_rd_v1;

  logic              w_bank_en;
  logic [NBYTES-1:0] w_bank_we;
  logic [AW-1:0]     w_bank_addr;
  logic [DATA_W-1:0] w_bank_di;
  logic [DATA_W-1:0] w_bank_do;

  // FSM state register. READY is registered from the next state so it rises
  // on the edge that ends CLEAR, or the first edge after reset without fill.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_ctrl <= '{state: RESET_STATE, ready: 1'b0};
    end else begin
      r_ctrl <= '{state: w_state_next, ready: (w_state_next == RUN)};
    end
  end

  always_comb begin
    w_state_next = r_ctrl.state;
    case (r_ctrl.state)
      CLEAR:   if (r_clr_cnt == AW'(WORDS - 1)) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = r_ctrl.state;
    endcase
  end

  // Reset during CLEAR restarts the fill from word 0.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_clr_cnt <= '0;
    end else if (r_ctrl.state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign w_accept = EN && r_ctrl.ready;

  // Accepted accesses are captured first and presented to the banks one edge
  // later; a read issued right after a write therefore sees the new data.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_req_en   <= 1'b0;
      r_req_we   <= '0;
      r_req_addr <= '0;
      r_req_di   <= '0;
    end else begin
      r_req_en   <= w_accept;
      r_req_we   <= WE;
      r_req_addr <= A;
      r_req_di   <= Di;
    end
  end

  // The zero fill owns the banks while clearing; user requests cannot exist
  // then because READY is low.
  always_comb begin
    w_bank_en   = r_req_en;
    w_bank_we   = r_req_we;
    w_bank_addr = r_req_addr;
    w_bank_di   = r_req_di;
    if (r_ctrl.state == CLEAR) begin
      w_bank_en   = 1'b1;
      w_bank_we   = '1;
      w_bank_addr = r_clr_cnt;
      w_bank_di   = '0;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    dffram_bank #(
      .WORDS  (WORDS),
      .BANK_W (BANK_W)
    ) u_bank (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .i_en   (w_bank_en),
      .i_we   (w_bank_we[b*BANK_BYTES +: BANK_BYTES]),
      .i_addr (w_bank_addr),
      .i_di   (w_bank_di[b*BANK_W +: BANK_W]),
      .o_do   (w_bank_do[b*BANK_W +: BANK_W])
    );
  end

  // Marks the cycle in which the banks present fresh read data.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rd_v1 <= 1'b0;
    end else begin
      r_rd_v1 <= r_req_en && (r_req_we == '0);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_valid;
    logic [DATA_W-1:0] r_do;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_valid <= 1'b0;
        r_do    <= '0;
      end else begin
        r_valid <= r_rd_v1;
        if (r_rd_v1) r_do <= w_bank_do;
      end
    end

    assign Do    = r_do;
    assign VALID = r_valid;
  end else begin : g_out_direct
    // Bank read registers only change on reads, so Do holds between results.
    assign Do    = w_bank_do;
    assign VALID = r_rd_v1;
  end

  assign READY = r_ctrl.ready;

endmodule

// File: tb/tb_dffram_banked_ctrl.sv
module tb_dffram_banked_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  int edges = 0;
  always @(posedge clk) edges++;

  // ---------------- DUT A: defaults (256x64, OUT_REG=1, clear) ----------------
  localparam int LAT_A = 2;
  logic        en_a;
  logic [7:0]  we_a;
  logic [7:0]  a_a;
  logic [63:0] di_a;
  logic [63:0] do_a;
  logic        valid_a, ready_a;

  dffram_banked_ctrl u_dut_a (
    .CLK(clk), .RSTn(rstn), .EN(en_a), .WE(we_a), .A(a_a), .Di(di_a),
    .Do(do_a), .VALID(valid_a), .READY(ready_a)
  );

  // ---------------- DUT B: 64x128, OUT_REG=0, no clear ----------------
  logic         en_b;
  logic [15:0]  we_b;
  logic [5:0]   a_b;
  logic [127:0] di_b;
  logic [127:0] do_b;
  logic         valid_b, ready_b;

  dffram_banked_ctrl #(
    .WORDS(64), .DATA_W(128), .BANK_W(32), .OUT_REG(0), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .CLK(clk), .RSTn(rstn), .EN(en_b), .WE(we_b), .A(a_b), .Di(di_b),
    .Do(do_b), .VALID(valid_b), .READY(ready_b)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [63:0] mdl [256];
  logic [63:0] exp_q[$];
  int          due_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every read result must arrive exactly on its due cycle, in order.
  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (due_q.size() != 0 && due_q[0] == edges) begin
        chk("a_read_data", do_a, exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        chk("a_valid_cycle", edges, (due_q.size() != 0) ? due_q[0] : -1);
      end
    end else if (due_q.size() != 0 && due_q[0] == edges) begin
      chk("a_valid_missing", valid_a, 1'b1);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic en, input logic [7:0] we, input logic [7:0] a,
                       input logic [63:0] d);
    en_a = en; we_a = we; a_a = a; di_a = d;
    if (en && ready_a === 1'b1) begin
      if (we != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (we[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
        end
      end else begin
        exp_q.push_back(mdl[a]);
        due_q.push_back(edges + 1 + LAT_A);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    en_a = 1'b0;
    while (due_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("a_drain", due_q.size(), 0);
  endtask

  // Counts cycles until READY, attempting a write to A=5 during the fill.
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    foreach (mdl[i]) mdl[i] = '0;
    while (ready_a !== 1'b1 && n < 400) begin
      issue(n == 10, 8'hFF, 8'h05, '1);
      n++;
    end
    chk(tag, n, 256);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] pb;
  logic [127:0] vals_b [5];

  initial begin
    rstn = 1'b0;
    en_a = 0; we_a = 0; a_a = 0; di_a = 0;
    en_b = 0; we_b = 0; a_b = 0; di_b = 0;
    repeat (3) @(negedge clk);
    chk("a_reset_ready", ready_a, 1'b0);
    chk("a_reset_valid", valid_a, 1'b0);
    chk("a_reset_do", do_a, 64'h0);

    // Zero fill after reset: READY low for exactly 256 cycles.
    rstn = 1'b1;
    count_clear("a_clear_cycles");

    // Cleared words read as zero.
    issue(1, 8'h00, 8'h00, '0); issue(0, 0, 0, 0);
    issue(1, 8'h00, 8'h7F, '0); issue(0, 0, 0, 0);
    issue(1, 8'h00, 8'hFF, '0);
    issue(1, 8'h00, 8'h05, '0);
    drain();

    // Full write then read.
    issue(1, 8'hFF, 8'h10, 64'h0123456789ABCDEF);
    issue(1, 8'h00, 8'h10, '0);
    drain();
    chk("a_full_word", do_a, 64'h0123456789ABCDEF);

    // Partial write across both banks; Do holds through the write.
    issue(1, 8'h81, 8'h10, 64'hAA000000000000BB);
    issue(0, 0, 0, 0);
    chk("a_do_hold_on_write", do_a, 64'h0123456789ABCDEF);
    issue(1, 8'h00, 8'h10, '0);
    drain();
    chk("a_partial_word", do_a, 64'hAA23456789ABCDBB);

    // Back-to-back burst.
    for (int i = 1; i <= 4; i++) issue(1, 8'hFF, 8'(i), 64'(i * 17));
    for (int i = 1; i <= 4; i++) issue(1, 8'h00, 8'(i), '0);
    drain();
    chk("a_burst_last", do_a, 64'h44);

    // Random traffic against the model.
    repeat (400) begin
      logic        en_r;
      logic [7:0]  we_r, a_r;
      en_r = ($urandom_range(0, 3) != 0);
      we_r = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      a_r  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      issue(en_r, we_r, a_r, {$urandom, $urandom});
    end
    drain();

    // Reset with a read in flight: result is discarded.
    issue(1, 8'hFF, 8'h05, 64'hDEADBEEFCAFEF00D);
    issue(1, 8'h00, 8'h03, '0);
    rstn = 1'b0;
    due_q.delete();
    exp_q.delete();
    en_a = 1'b0;
    #1;
    chk("a_flush_valid", valid_a, 1'b0);
    chk("a_flush_do", do_a, 64'h0);
    chk("a_flush_ready", ready_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("a_flush_no_valid", valid_a, 1'b0);

    // Reset at clear cycle 100 restarts the fill.
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    chk("a_mid_clear_ready", ready_a, 1'b0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    count_clear("a_clear_restart_cycles");
    issue(1, 8'h00, 8'h05, '0);
    issue(1, 8'h00, 8'h10, '0);
    drain();
    chk("a_clear_blocks_write", do_a, 64'h0);

    // ---------------- DUT B ----------------
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_reset_ready", ready_b, 1'b0);
    chk("b_reset_do", do_b, 128'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("b_ready_one_cycle", ready_b, 1'b1);

    pb = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    en_b = 1; we_b = 16'hFFFF; a_b = 6'd63; di_b = pb;
    @(negedge clk);
    we_b = 16'h0000;
    @(negedge clk);
    en_b = 0;
    @(negedge clk);
    chk("b_valid", valid_b, 1'b1);
    chk("b_full_word", do_b, pb);
    @(negedge clk);
    chk("b_valid_one_cycle", valid_b, 1'b0);
    chk("b_do_hold", do_b, pb);

    en_b = 1; we_b = 16'h8001; a_b = 6'd63; di_b = '0;
    @(negedge clk);
    we_b = 16'h0000;
    @(negedge clk);
    en_b = 0;
    @(negedge clk);
    chk("b_partial_word", do_b, {8'h00, pb[119:8], 8'h00});

    for (int i = 1; i <= 4; i++) begin
      vals_b[i] = {$urandom, $urandom, $urandom, $urandom};
      en_b = 1; we_b = 16'hFFFF; a_b = 6'(i); di_b = vals_b[i];
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        en_b = 1; we_b = 16'h0000; a_b = 6'(i + 1);
      end else begin
        en_b = 0;
      end
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        chk("b_burst_valid", valid_b, 1'b1);
        chk("b_burst_data", do_b, vals_b[i]);
      end else if (i == 5) begin
        chk("b_burst_end", valid_b, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
